// File: rtl/conv_frame_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// conv_frame_sequencer_pkg
// Shared definitions for the frame sequencer of the 3x3 convolution path:
//   - state_t : FSM state encoding (S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE)
//   - frame_count() : pixels per frame (WIDTH*HEIGHT)
//   - exp_count()   : valid 3x3 results per frame ((WIDTH-2)*(HEIGHT-2))
// No ports.
// ---------------------------------------------------------------------------
package conv_frame_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic int frame_count(input int width, input int height);
        return width * height;
    endfunction

    // A 3x3 window without padding loses one pixel on every border.
    function automatic int exp_count(input int width, input int height);
        return (width - 2) * (height - 2);
    endfunction

endpackage

// File: rtl/seq_addr_counter.sv
// ---------------------------------------------------------------------------
// seq_addr_counter
// Loadable, enable-gated address counter that saturates at LIMIT.
// The internal count is one bit wider than the address so that a full
// 2**AW-entry frame can be represented without wrapping.
// Ports:
//   clk      in   1     clock, rising edge
//   rst_n    in   1     asynchronous reset, active-low
//   load     in   1     load load_val (has priority over en)
//   load_val in   AW+1  value to load
//   en       in   1     count up by one (ignored once tc is set)
//   addr     out  AW    low AW bits of the count
//   tc       out  1     terminal count: count == LIMIT
// ---------------------------------------------------------------------------
module seq_addr_counter #(
    parameter int AW    = 16,
    parameter int LIMIT = 65536
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW:0]   load_val,
    input  logic          en,
    output logic [AW-1:0] addr,
    output logic          tc
);

    localparam logic [AW:0] LIM = (AW+1)'(LIMIT);

    logic [AW:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

    assign addr = count[AW-1:0];
    assign tc   = (count == LIM);

endmodule

// File: rtl/conv_frame_sequencer.sv
// ---------------------------------------------------------------------------
// conv_frame_sequencer
// Frame-level controller for the 3x3 line-buffer convolution path. A start
// pulse clears the line buffer, streams one WIDTH x HEIGHT frame from a
// sync-read pixel memory into it, and stores every valid convolution result
// at sequential addresses of a result memory. The frame ends with a one-cycle
// done pulse, or with a sticky error when the datapath goes quiet for
// DRAIN_MAX cycles before all results arrived.
// Ports:
//   i_CLK        in   1     clock, rising edge
//   i_reset      in   1     asynchronous reset, active-low
//   i_start      in   1     frame start request, sampled in IDLE only
//   i_pause      in   1     suppress new pixel reads this cycle
//   o_busy       out  1     high in every state except IDLE
//   o_done       out  1     one-cycle pulse at frame end
//   o_err        out  1     sticky timeout flag, cleared by the next start
//   o_buf_clear  out  1     one-cycle line buffer clear
//   o_rd_en      out  1     pixel memory read enable
//   o_rd_addr    out  AW    pixel memory read address
//   i_rd_data    in   BITW  pixel data, valid one cycle after o_rd_en
//   o_pix_valid  out  1     pixel strobe to the line buffer
//   o_pix        out  BITW  pixel to the line buffer
//   i_conv_valid in   1     result strobe from the conv datapath
//   i_conv       in   ACCW  convolution result
//   o_wr_en      out  1     result memory write enable
//   o_wr_addr    out  AW    result memory write address
//   o_wr_data    out  ACCW  result memory write data
// ---------------------------------------------------------------------------
module conv_frame_sequencer
    import conv_frame_sequencer_pkg::*;
#(
    parameter int BITW      = 8,
    parameter int ACCW      = 20,
    parameter int WIDTH     = 256,
    parameter int HEIGHT    = 256,
    parameter int AW        = 16,
    parameter int DRAIN_MAX = 64
) (
    input  logic            i_CLK,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_pause,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,
    output logic            o_buf_clear,
    output logic            o_rd_en,
    output logic [AW-1:0]   o_rd_addr,
    input  logic [BITW-1:0] i_rd_data,
    output logic            o_pix_valid,
    output logic [BITW-1:0] o_pix,
    input  logic            i_conv_valid,
    input  logic [ACCW-1:0] i_conv,
    output logic            o_wr_en,
    output logic [AW-1:0]   o_wr_addr,
    output logic [ACCW-1:0] o_wr_data
);

    localparam int FRAME = frame_count(WIDTH, HEIGHT);
    localparam int EXP   = exp_count(WIDTH, HEIGHT);
    localparam int DW    = $clog2(DRAIN_MAX + 1);

    localparam logic [AW-1:0] RD_LAST     = AW'(FRAME - 1);
    localparam logic [DW-1:0] DRAIN_LIMIT = DW'(DRAIN_MAX);

    state_t          state;
    logic            cnt_load;
    logic            in_stream;
    logic            last_rd;
    logic [AW-1:0]   rd_cnt;
    logic [AW-1:0]   wr_cnt;
    logic            rd_tc;
    logic            wr_tc;
    logic [DW-1:0]   drain_cnt;
    logic            pix_vld_p1;

    assign cnt_load  = (state == S_IDLE) && i_start;
    assign in_stream = (state == S_FEED) || (state == S_DRAIN);

    // Read side: one read per unpaused FEED cycle, never past the frame.
    assign o_rd_en   = (state == S_FEED) && !i_pause && !rd_tc;
    assign o_rd_addr = o_rd_en ? rd_cnt : '0;
    assign last_rd   = o_rd_en && (rd_cnt == RD_LAST);

    // Write side: results pass straight through until EXP have been stored.
    assign o_wr_en   = in_stream && i_conv_valid && !wr_tc;
    assign o_wr_addr = o_wr_en ? wr_cnt : '0;
    assign o_wr_data = o_wr_en ? i_conv : '0;

    seq_addr_counter #(
        .AW    (AW),
        .LIMIT (FRAME)
    ) u_rd_cnt (
        .clk      (i_CLK),
        .rst_n    (i_reset),
        .load     (cnt_load),
        .load_val ('0),
        .en       (o_rd_en),
        .addr     (rd_cnt),
        .tc       (rd_tc)
    );

    seq_addr_counter #(
        .AW    (AW),
        .LIMIT (EXP)
    ) u_wr_cnt (
        .clk      (i_CLK),
        .rst_n    (i_reset),
        .load     (cnt_load),
        .load_val ('0),
        .en       (o_wr_en),
        .addr     (wr_cnt),
        .tc       (wr_tc)
    );

    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            state       <= S_IDLE;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_buf_clear <= 1'b0;
            drain_cnt   <= '0;
        end else begin
            o_done      <= 1'b0;
            o_buf_clear <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state       <= S_CLEAR;
                        o_busy      <= 1'b1;
                        o_buf_clear <= 1'b1;
                        o_err       <= 1'b0;
                        drain_cnt   <= '0;
                    end
                end
                S_CLEAR: begin
                    state <= S_FEED;
                end
                S_FEED: begin
                    // All results may already be in; the frame still ends
                    // only once the last pixel read has gone out.
                    if (last_rd) begin
                        if (wr_tc) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (wr_tc) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end else if (drain_cnt == DRAIN_LIMIT) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                        o_err  <= 1'b1;
                    end else if (i_conv_valid) begin
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // Stage p1: read data returns one cycle after the read; the strobe
    // follows the read enable so an in-flight read always lands.
    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            pix_vld_p1 <= 1'b0;
        end else begin
            pix_vld_p1 <= o_rd_en;
        end
    end

    assign o_pix_valid = pix_vld_p1;
    assign o_pix       = pix_vld_p1 ? i_rd_data : '0;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
module tb_conv_frame_sequencer;

    localparam int W     = 8;
    localparam int H     = 6;
    localparam int AW    = 6;
    localparam int BITW  = 8;
    localparam int ACCW  = 20;
    localparam int DMAX  = 8;
    localparam int FRAME = W * H;
    localparam int EXP   = (W - 2) * (H - 2);

    logic            clk;
    logic            rst_n;
    logic            i_start;
    logic            i_pause;
    logic            o_busy;
    logic            o_done;
    logic            o_err;
    logic            o_buf_clear;
    logic            o_rd_en;
    logic [AW-1:0]   o_rd_addr;
    logic [BITW-1:0] rd_data;
    logic            o_pix_valid;
    logic [BITW-1:0] o_pix;
    logic            conv_valid;
    logic [ACCW-1:0] conv;
    logic            o_wr_en;
    logic [AW-1:0]   o_wr_addr;
    logic [ACCW-1:0] o_wr_data;

    // datapath model and injected strobes
    logic            dp_valid;
    logic [ACCW-1:0] dp_conv;
    int              dp_pc;
    int              dp_k;
    logic            inj_valid;
    logic [ACCW-1:0] inj_conv;
    int              withhold;
    bit              flood;
    bit              pause_toggle;

    logic [BITW-1:0] mem    [FRAME];
    logic [BITW-1:0] pixbuf [FRAME];

    int n_checks = 0;
    int n_fail   = 0;

    // per-frame observations
    int              rd_n, pix_n, wr_n, done_n, busy_n, max_wr, total_clr;
    logic [ACCW-1:0] first_wr, last_wr;
    bit              prev_rd;

    assign conv_valid = dp_valid | inj_valid;
    assign conv       = dp_valid ? dp_conv : inj_conv;

    conv_frame_sequencer #(
        .BITW(BITW), .ACCW(ACCW), .WIDTH(W), .HEIGHT(H), .AW(AW), .DRAIN_MAX(DMAX)
    ) dut (
        .i_CLK        (clk),
        .i_reset      (rst_n),
        .i_start      (i_start),
        .i_pause      (i_pause),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_buf_clear  (o_buf_clear),
        .o_rd_en      (o_rd_en),
        .o_rd_addr    (o_rd_addr),
        .i_rd_data    (rd_data),
        .o_pix_valid  (o_pix_valid),
        .o_pix        (o_pix),
        .i_conv_valid (conv_valid),
        .i_conv       (conv),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // sync-read pixel memory
    always @(posedge clk) begin
        if (o_rd_en) rd_data <= mem[o_rd_addr];
    end

    // identity 3x3 conv: once a window is complete, emit its centre pixel
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_pc    <= 0;
            dp_k     <= 0;
            dp_valid <= 1'b0;
            dp_conv  <= '0;
        end else if (o_buf_clear) begin
            dp_pc    <= 0;
            dp_k     <= 0;
            dp_valid <= 1'b0;
        end else begin
            dp_valid <= 1'b0;
            if (o_pix_valid) begin
                pixbuf[dp_pc] <= o_pix;
                dp_pc <= dp_pc + 1;
                if ((dp_pc / W) >= 2 && (dp_pc % W) >= 2) begin
                    if (dp_k < EXP - withhold) begin
                        dp_valid <= 1'b1;
                        dp_conv  <= {{(ACCW-BITW){1'b0}}, pixbuf[dp_pc - W - 1]};
                    end
                    dp_k <= dp_k + 1;
                end
            end
        end
    end

    function automatic logic [ACCW-1:0] exp_res(input int k);
        return {{(ACCW-BITW){1'b0}}, mem[(k / (W - 2) + 1) * W + (k % (W - 2)) + 1]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({o_busy, o_done, o_err, o_buf_clear, o_rd_en, o_rd_addr, o_pix_valid,
                    o_pix, o_wr_en, o_wr_addr, o_wr_data});
    endfunction

    // per-cycle compare against the frame model
    initial begin
        rd_n = 0; pix_n = 0; wr_n = 0; done_n = 0; busy_n = 0; max_wr = -1;
        total_clr = 0; first_wr = '0; last_wr = '0; prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_rd = 1'b0;
            end else begin
                if (o_buf_clear) begin
                    rd_n = 0; pix_n = 0; wr_n = 0; done_n = 0; busy_n = 0; max_wr = -1;
                    total_clr++;
                end
                if (o_busy) busy_n++;
                if (o_done) done_n++;
                if (o_pix_valid || prev_rd)
                    check("pix_lag", 64'(o_pix_valid), 64'(prev_rd));
                prev_rd = o_rd_en;
                if (o_rd_en) begin
                    check("rd_addr", 64'(o_rd_addr), 64'(rd_n));
                    rd_n++;
                end
                if (o_pix_valid) begin
                    if (pix_n < FRAME) check("pix_data", 64'(o_pix), 64'(mem[pix_n]));
                    else               check("pix_extra", 64'(o_pix_valid), 64'(0));
                    pix_n++;
                end
                if (conv_valid && !o_busy)
                    check("wr_in_idle", 64'(o_wr_en), 64'(0));
                if (o_wr_en) begin
                    if (wr_n < EXP) begin
                        check("wr_addr", 64'(o_wr_addr), 64'(wr_n));
                        check("wr_data", 64'(o_wr_data), 64'(exp_res(wr_n)));
                    end else begin
                        check("wr_beyond_exp", 64'(o_wr_en), 64'(0));
                    end
                    if (wr_n == 0) first_wr = o_wr_data;
                    last_wr = o_wr_data;
                    if (int'(o_wr_addr) > max_wr) max_wr = int'(o_wr_addr);
                    wr_n++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    // Runs until the done pulse, then one more cycle so the done cycle is sampled.
    task automatic run_to_done();
        bit seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            i_pause   = pause_toggle ? ~i_pause : 1'b0;
            inj_valid = flood && (wr_n >= EXP);
            step();
            if (o_done) seen = 1'b1;
        end
        i_pause   = 1'b0;
        inj_valid = 1'b0;
        if (!seen) check("done_timeout", 64'(o_done), 64'(1));
        step();
    endtask

    task automatic check_frame(input int exp_wr, input bit exp_err);
        check("frame_reads",     64'(rd_n),   64'(FRAME));
        check("frame_pixels",    64'(pix_n),  64'(FRAME));
        check("frame_writes",    64'(wr_n),   64'(exp_wr));
        check("frame_max_waddr", 64'(max_wr), 64'(exp_wr - 1));
        check("frame_done_once", 64'(done_n), 64'(1));
        check("frame_err",       64'(o_err),  64'(exp_err));
        check("idle_after_done", 64'(o_busy), 64'(0));
    endtask

    initial begin
        int clr0;
        rst_n = 1'b0; i_start = 1'b0; i_pause = 1'b0;
        inj_valid = 1'b0; inj_conv = 20'hABCDE;
        withhold = 0; flood = 1'b0; pause_toggle = 1'b0;
        for (int i = 0; i < FRAME; i++) mem[i] = 8'(i * 7 + 3);

        // reset state
        repeat (2) step();
        check("reset_outputs", all_outs(), 64'(0));
        rst_n = 1'b1;
        step();
        check("idle_outputs", all_outs(), 64'(0));

        // 1: reset in the middle of FEED
        start_frame();
        check("s1_clear", 64'(o_buf_clear), 64'(1));
        repeat (10) step();
        check("s1_feeding", 64'(o_rd_en), 64'(1));
        rst_n = 1'b0;
        #1;
        check("s1_async_reset", all_outs(), 64'(0));
        step();
        check("s1_reset_held", all_outs(), 64'(0));
        rst_n = 1'b1;
        step();
        check("s1_idle", 64'(o_busy), 64'(0));

        // 2: clean frame, no pause
        start_frame();
        check("s2_clear", 64'(o_buf_clear), 64'(1));
        step();
        check("s2_clear_one_cycle", 64'(o_buf_clear), 64'(0));
        run_to_done();
        check_frame(EXP, 1'b0);
        check("s2_frame_cycles", 64'(busy_n),   64'(53));
        check("s2_first_result", 64'(first_wr), 64'(66));
        check("s2_last_result",  64'(last_wr),  64'(13));
        step();
        check("s2_done_pulse_gone", 64'(o_done), 64'(0));

        // 3: pause toggling every cycle
        pause_toggle = 1'b1;
        start_frame();
        run_to_done();
        pause_toggle = 1'b0;
        check_frame(EXP, 1'b0);
        check("s3_frame_cycles_2x", 64'(busy_n >= 96 && busy_n <= 104), 64'(1));

        // 4: last 4 results withheld -> timeout
        withhold = 4;
        start_frame();
        run_to_done();
        withhold = 0;
        check_frame(EXP - 4, 1'b1);
        check("s4_timeout_cycles", 64'(busy_n >= 58 && busy_n <= 60), 64'(1));
        step();
        check("s4_err_sticky", 64'(o_err), 64'(1));

        // 5: conv strobe in IDLE, start held through the frame
        inj_valid = 1'b1;
        step();
        inj_valid = 1'b0;
        clr0 = total_clr;
        i_start = 1'b1;
        step();
        check("s5_err_cleared", 64'(o_err), 64'(0));
        check("s5_clear", 64'(o_buf_clear), 64'(1));
        run_to_done();
        check_frame(EXP, 1'b0);
        check("s5_single_clear", 64'(total_clr - clr0), 64'(1));
        step();
        check("s5_restart_after_done", 64'(o_buf_clear), 64'(1));
        i_start = 1'b0;
        run_to_done();
        check_frame(EXP, 1'b0);

        // 6: extra strobes once all results are stored
        flood = 1'b1;
        start_frame();
        run_to_done();
        flood = 1'b0;
        check_frame(EXP, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
